yannickreiss_diamond_field: RTL and testbench
=============================================

# yannickreiss_diamond_field

Field-side sequencer for the railway switch diamond. It turns raw track sensor pulses into latched request bits for the diamond controller's corner inputs [0]=NW, [1]=SW, [2]=NE, [3]=SE. It also receives the controller's corner signals and switch command, drives the point motor with timed throw pulses, and supervises point feedback. Signal lamps are passed to the track only when the points are confirmed in the commanded position.

## Interface
- THROW_CYC, 8: motor pulse length in cycles (1..254).
- FB_TIMEOUT, 64: cycles from throw start until missing feedback is a fault. Must satisfy THROW_CYC < FB_TIMEOUT ≤ 255.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arrive  in  4  per-corner approach sensor, level; rising edge means a train is present.
- depart  in  4  per-corner exit sensor, level; rising edge means the train has cleared.
- sig  in  4  corner signals from the diamond controller.
- set_sw  in  1  switch command from the controller (1 = diverging/set).
- points_fb  in  1  point position feedback (1 = set, 0 = straight).
- req  out  4  latched requests to the controller corner inputs.
- sig_out  out  4  qualified signal lamps.
- motor_set, motor_clr  out  1 each  point motor drive pulses.
- fault  out  1  sticky point fault.

## Operation
- Edge detection: registered copies of arrive and depart; both reset to 0.
- Request latch, per corner i:
  - rise of arrive[i] sets req[i];
  - rise of depart[i] clears req[i];
  - both rising in the same cycle: clear wins, req[i]=0.
- Request latching continues in every FSM state, including FAULT.
- FSM states: STRAIGHT, SET, TO_SET, TO_STR, FAULT. Reset state: STRAIGHT.
- 8-bit counter cnt:
  - cleared on every state entry;
  - increments each cycle in TO_SET or TO_STR;
  - saturates at 255.
- Stable condition (st): (STRAIGHT & !set_sw & !points_fb) | (SET & set_sw & points_fb).
- Transitions:
  - STRAIGHT→TO_SET when set_sw=1 and the current sig_out register is 0000.
  - SET→TO_STR when set_sw=0 and the current sig_out register is 0000.
  - TO_SET→SET when cnt ≥ THROW_CYC and points_fb=1.
  - TO_STR→STRAIGHT when cnt ≥ THROW_CYC and points_fb=0.
  - TO_SET or TO_STR → FAULT when cnt = FB_TIMEOUT and the completing condition is false.
  - STRAIGHT or SET → FAULT when points_fb disagrees with the state for FB_TIMEOUT consecutive cycles, regardless of set_sw. A separate mismatch counter handles this and clears on any agreement.
  - FAULT is left only by reset.
- Motor outputs:
  - motor_set = TO_SET & cnt < THROW_CYC;
  - motor_clr = TO_STR & cnt < THROW_CYC;
  - both are registered decodes, never high together, and 0 in FAULT.
- Command reversal during a throw is ignored. The throw completes to its original target, then the new command is evaluated from the stable state.
- Signal qualification: sig_out ← sig & {4{st}}, registered. It is 0000 in every non-stable state, in FAULT, and whenever set_sw disagrees with the state.
- fault = (state == FAULT).

## Timing
- Reset (async assert, sync release):
  - req, sig_out, motor_set, motor_clr, fault are all 0;
  - state is STRAIGHT; cnt and the edge registers are 0.
- Reset asserted mid-throw drops the motor drive immediately.
- req latency: a sensor rise sampled at edge e appears on req after edge e+1 (edge register, then latch).
- Throw latency, with set_sw changing before edge t:
  - If sig_out=0000 at t: TO_SET is entered at t, and motor_set is high for exactly THROW_CYC cycles after t.
  - If sig_out≠0000 at t: sig_out clears at t, TO_SET is entered at t+1, and the throw shifts by one cycle.
- Completion: SET is entered at the first edge with cnt ≥ THROW_CYC and points_fb=1. sig_out may rise at the following edge.
- Early feedback during the pulse does not shorten the pulse.
- The fault edge is FB_TIMEOUT cycles after throw entry. fault is high from that edge on.

## Test plan
- Reset: drive arrive=1111 mid-throw, then pull rst_n low → req, sig_out, motor_set, motor_clr and fault are 0 immediately; after release, state is STRAIGHT.
- Requests: pulse arrive[0] → req=0001 two edges later; pulse depart[0] → req=0000; raise arrive[2] and depart[2] in the same cycle → req[2] stays 0.
- Normal throw: sig_out=0000, set_sw 0→1, points_fb rises 12 cycles later → motor_set high exactly 8 cycles, SET is entered on the edge sampling fb=1, and sig_out=sig (e.g. 0110) one edge later.
- Busy throw: sig=0101 with sig_out=0101 in STRAIGHT, then set_sw→1 → sig_out=0000 at the first edge and motor_set rises one edge later.
- Timeout: throw with points_fb held at 0 → fault=1 at cnt=64; motors stay 0 and sig_out stays 0000 even with sig=1111; fault clears only via rst_n.
- Reversal: set_sw→1, then back to 0 at cnt=3, fb follows the motor → the throw completes to SET, then a TO_STR throw follows with motor_clr high for 8 cycles, ending in STRAIGHT.

Source files
------------

// File: rtl/yannickreiss_diamond_field.sv
// yannickreiss_diamond_field
//
// Field-side sequencer for a railway switch diamond.
//  - Turns raw approach/exit sensor levels into latched per-corner request bits
//    ([0]=NW, [1]=SW, [2]=NE, [3]=SE) for the diamond controller.
//  - Drives the point motor with timed throw pulses on a change of switch command.
//  - Supervises point feedback; a missing or wrong feedback ends in a sticky fault.
//  - Passes signal lamps to the track only while the points are confirmed in the
//    commanded position.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset, released synchronously by the system
//   arrive     per-corner approach sensor levels (rise = train present)
//   depart     per-corner exit sensor levels (rise = train cleared)
//   sig        corner signals from the diamond controller
//   set_sw     switch command (1 = diverging/set)
//   points_fb  point position feedback (1 = set, 0 = straight)
//   req        latched corner requests
//   sig_out    qualified signal lamps
//   motor_set  point motor drive towards set
//   motor_clr  point motor drive towards straight
//   fault      sticky point fault

module yannickreiss_diamond_field #(
    parameter int unsigned THROW_CYC  = 8,
    parameter int unsigned FB_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] arrive,
    input  logic [3:0] depart,
    input  logic [3:0] sig,
    input  logic       set_sw,
    input  logic       points_fb,
    output logic [3:0] req,
    output logic [3:0] sig_out,
    output logic       motor_set,
    output logic       motor_clr,
    output logic       fault
);

    // FSM encoding
    localparam logic [2:0] StStraight = 3'd0;
    localparam logic [2:0] StSet      = 3'd1;
    localparam logic [2:0] StToSet    = 3'd2;
    localparam logic [2:0] StToStr    = 3'd3;
    localparam logic [2:0] StFault    = 3'd4;

    localparam logic [7:0] ThrowLim   = 8'(THROW_CYC);
    localparam logic [7:0] TimeoutLim = 8'(FB_TIMEOUT);

    // Sensor edge detection and request latch
    logic [3:0] arrive_q;
    logic [3:0] depart_q;
    logic [3:0] arrive_rise_q;
    logic [3:0] depart_rise_q;
    logic [3:0] req_q;
    logic [3:0] req_d;

    // Point sequencing
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_inc;
    logic [7:0] mis_q;
    logic [7:0] mis_d;
    logic [7:0] mis_inc;

    // Registered outputs
    logic [3:0] sig_out_q;
    logic [3:0] sig_out_d;
    logic       motor_set_q;
    logic       motor_set_d;
    logic       motor_clr_q;
    logic       motor_clr_d;
    logic       fault_q;
    logic       fault_d;

    // Decoded conditions
    logic       st;
    logic       disagree;
    logic       mis_hit;
    logic       throw_timeout;
    logic       throw_done_set;
    logic       throw_done_str;
    logic       lamps_dark;

    //--------------------------------------------------------------------------
    // Request latch: a rise registered on one edge is applied on the next.
    // An exit rise in the same cycle as an approach rise wins.
    //--------------------------------------------------------------------------
    always_comb begin
        req_d = (req_q | arrive_rise_q) & ~depart_rise_q;
    end

    //--------------------------------------------------------------------------
    // Condition decode
    //--------------------------------------------------------------------------
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign mis_inc = (mis_q == 8'hFF) ? mis_q : mis_q + 8'd1;

    assign st = ((state_q == StStraight) && !set_sw && !points_fb) ||
                ((state_q == StSet) && set_sw && points_fb);

    // Feedback contradicting a settled position, independent of the command.
    assign disagree = ((state_q == StStraight) && points_fb) ||
                      ((state_q == StSet) && !points_fb);

    // The fault lands on the edge at which the run length reaches FB_TIMEOUT.
    assign mis_hit = disagree && (mis_inc == TimeoutLim);

    // Likewise the throw faults on the edge at which cnt reaches FB_TIMEOUT,
    // i.e. FB_TIMEOUT cycles after entering the throw state.
    assign throw_timeout = (cnt_inc == TimeoutLim);

    // Early feedback cannot finish the throw: the full pulse always runs.
    assign throw_done_set = (cnt_q >= ThrowLim) && points_fb;
    assign throw_done_str = (cnt_q >= ThrowLim) && !points_fb;

    // A throw may only start once the lamps on the track are already dark.
    assign lamps_dark = (sig_out_q == 4'b0000);

    //--------------------------------------------------------------------------
    // Next state
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StStraight: begin
                if (mis_hit) begin
                    state_d = StFault;
                end else if (set_sw && lamps_dark) begin
                    state_d = StToSet;
                end
            end
            StSet: begin
                if (mis_hit) begin
                    state_d = StFault;
                end else if (!set_sw && lamps_dark) begin
                    state_d = StToStr;
                end
            end
            // The command is not looked at during a throw; a reversal is
            // picked up again from the settled state.
            StToSet: begin
                if (throw_done_set) begin
                    state_d = StSet;
                end else if (throw_timeout) begin
                    state_d = StFault;
                end
            end
            StToStr: begin
                if (throw_done_str) begin
                    state_d = StStraight;
                end else if (throw_timeout) begin
                    state_d = StFault;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StFault;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Throw counter and feedback mismatch counter
    //--------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if ((state_q == StToSet) || (state_q == StToStr)) begin
            cnt_d = cnt_inc;
        end
    end

    always_comb begin
        mis_d = 8'd0;
        if ((state_d == state_q) && disagree) begin
            mis_d = mis_inc;
        end
    end

    //--------------------------------------------------------------------------
    // Output decode, registered from the next state
    //--------------------------------------------------------------------------
    always_comb begin
        sig_out_d   = sig & {4{st}};
        motor_set_d = (state_d == StToSet) && (cnt_d < ThrowLim);
        motor_clr_d = (state_d == StToStr) && (cnt_d < ThrowLim);
        fault_d     = (state_d == StFault);
    end

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arrive_q      <= 4'b0000;
            depart_q      <= 4'b0000;
            arrive_rise_q <= 4'b0000;
            depart_rise_q <= 4'b0000;
            req_q         <= 4'b0000;
        end else begin
            arrive_q      <= arrive;
            depart_q      <= depart;
            arrive_rise_q <= arrive & ~arrive_q;
            depart_rise_q <= depart & ~depart_q;
            req_q         <= req_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StStraight;
            cnt_q       <= 8'd0;
            mis_q       <= 8'd0;
            sig_out_q   <= 4'b0000;
            motor_set_q <= 1'b0;
            motor_clr_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mis_q       <= mis_d;
            sig_out_q   <= sig_out_d;
            motor_set_q <= motor_set_d;
            motor_clr_q <= motor_clr_d;
            fault_q     <= fault_d;
        end
    end

    assign req       = req_q;
    assign sig_out   = sig_out_q;
    assign motor_set = motor_set_q;
    assign motor_clr = motor_clr_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_yannickreiss_diamond_field.sv
// Self-checking bench for yannickreiss_diamond_field: directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model that
// tracks the points as a settled position or a throw in progress.

module tb_yannickreiss_diamond_field;

    localparam int unsigned THROW_CYC  = 8;
    localparam int unsigned FB_TIMEOUT = 64;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic [3:0] arrive    = 4'b0000;
    logic [3:0] depart    = 4'b0000;
    logic [3:0] sig       = 4'b0000;
    logic       set_sw    = 1'b0;
    logic       points_fb = 1'b0;
    logic [3:0] req;
    logic [3:0] sig_out;
    logic       motor_set;
    logic       motor_clr;
    logic       fault;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    // 0: points_fb driven by hand, 1: follows the motor at once,
    // 2: follows the motor slowly, 3: slow plus occasional glitches
    int   plant_mode = 0;
    logic fb_tgt     = 1'b0;

    yannickreiss_diamond_field #(
        .THROW_CYC (THROW_CYC),
        .FB_TIMEOUT(FB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arrive   (arrive),
        .depart   (depart),
        .sig      (sig),
        .set_sw   (set_sw),
        .points_fb(points_fb),
        .req      (req),
        .sig_out  (sig_out),
        .motor_set(motor_set),
        .motor_clr(motor_clr),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    //--------------------------------------------------------------------------
    // Reference model
    //--------------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]  a_prev;
        logic [3:0]  d_prev;
        logic [3:0]  a_pend;   // approach rises waiting to reach req
        logic [3:0]  d_pend;   // exit rises waiting to reach req
        logic [3:0]  req;
        logic [3:0]  sig_out;
        logic        ms;
        logic        mc;
        logic        flt;
        logic        pos;      // settled position: 0 straight, 1 set
        logic        moving;   // a throw is in progress
        logic        target;   // position the throw is heading to
        logic [31:0] age;      // cycles spent in the current throw
        logic [31:0] mis;      // consecutive contradicting feedback samples
    } model_t;

    model_t m;

    function automatic model_t step(input model_t c, input logic [3:0] a, input logic [3:0] d,
                                    input logic [3:0] s, input logic sw, input logic fb);
        model_t n;
        logic   stable;
        n = c;
        for (int i = 0; i < 4; i++) begin
            if (c.d_pend[i]) n.req[i] = 1'b0;
            else if (c.a_pend[i]) n.req[i] = 1'b1;
        end
        n.a_pend = a & ~c.a_prev;
        n.d_pend = d & ~c.d_prev;
        n.a_prev = a;
        n.d_prev = d;

        stable    = !c.flt && !c.moving && (sw == c.pos) && (fb == c.pos);
        n.sig_out = stable ? s : 4'b0000;

        if (!c.flt) begin
            if (c.moving) begin
                if ((c.age >= THROW_CYC) && (fb == c.target)) begin
                    n.moving = 1'b0;
                    n.pos    = c.target;
                    n.mis    = 0;
                end else if (c.age + 1 == FB_TIMEOUT) begin
                    n.flt = 1'b1;
                end else begin
                    n.age = c.age + 1;
                end
            end else begin
                n.mis = (fb != c.pos) ? c.mis + 1 : 0;
                if (n.mis == FB_TIMEOUT) begin
                    n.flt = 1'b1;
                end else if ((sw != c.pos) && (c.sig_out == 4'b0000)) begin
                    n.moving = 1'b1;
                    n.target = ~c.pos;
                    n.age    = 0;
                    n.mis    = 0;
                end
            end
        end
        n.ms = !n.flt && n.moving && n.target && (n.age < THROW_CYC);
        n.mc = !n.flt && n.moving && !n.target && (n.age < THROW_CYC);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m, arrive, depart, sig, set_sw, points_fb);
    end

    //--------------------------------------------------------------------------
    // Checking
    //--------------------------------------------------------------------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            check_val("req", 32'(req), 32'(m.req));
            check_val("sig_out", 32'(sig_out), 32'(m.sig_out));
            check_val("motor_set", 32'(motor_set), 32'(m.ms));
            check_val("motor_clr", 32'(motor_clr), 32'(m.mc));
            check_val("fault", 32'(fault), 32'(m.flt));
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers; cyc() returns 2 time units after a rising edge
    //--------------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #2;
        if (plant_mode != 0) begin
            if (motor_set) fb_tgt = 1'b1;
            else if (motor_clr) fb_tgt = 1'b0;
            if (plant_mode == 1) points_fb = fb_tgt;
            else if ($urandom_range(2) == 0) points_fb = fb_tgt;
            if ((plant_mode == 3) && ($urandom_range(59) == 0)) points_fb = ~points_fb;
        end
    endtask

    task automatic do_reset();
        arrive    = 4'b0000;
        depart    = 4'b0000;
        sig       = 4'b0000;
        set_sw    = 1'b0;
        points_fb = 1'b0;
        fb_tgt    = 1'b0;
        rst_n     = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ms_cnt;
        int mc_cnt;

        #1 rst_n = 1'b0;
        run = 1'b1;
        do_reset();
        check_val("rst_req", 32'(req), 0);
        check_val("rst_out", 32'({sig_out, motor_set, motor_clr, fault}), 0);

        // Requests: two-edge latency, clear, simultaneous rise
        arrive = 4'b0001;
        cyc();
        check_val("req_lat1", 32'(req), 0);
        cyc();
        check_val("req_lat2", 32'(req), 32'h1);
        arrive = 4'b0000;
        depart = 4'b0001;
        cyc();
        cyc();
        check_val("req_clr", 32'(req), 0);
        depart = 4'b0000;
        arrive = 4'b0100;
        depart = 4'b0100;
        cyc();
        cyc();
        cyc();
        check_val("req_both", 32'(req), 0);

        // Normal throw: feedback 12 cycles after the command
        do_reset();
        plant_mode = 0;
        set_sw     = 1'b1;
        ms_cnt     = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            ms_cnt += int'(motor_set);
        end
        points_fb = 1'b1;
        sig       = 4'b0110;
        cyc();
        check_val("norm_pre", 32'(sig_out), 0);
        cyc();
        check_val("norm_sig", 32'(sig_out), 32'h6);
        check_val("norm_pulse", 32'(ms_cnt), THROW_CYC);

        // Busy throw: lamps lit in STRAIGHT
        do_reset();
        sig = 4'b0101;
        cyc();
        cyc();
        check_val("busy_lit", 32'(sig_out), 32'h5);
        plant_mode = 1;
        set_sw     = 1'b1;
        cyc();
        check_val("busy_dark", 32'(sig_out), 0);
        check_val("busy_wait", 32'(motor_set), 0);
        cyc();
        check_val("busy_motor", 32'(motor_set), 1);
        repeat (20) cyc();
        check_val("busy_relit", 32'(sig_out), 32'h5);

        // Reversal at cnt=3
        do_reset();
        plant_mode = 1;
        set_sw     = 1'b1;
        ms_cnt     = 0;
        mc_cnt     = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            ms_cnt += int'(motor_set);
            mc_cnt += int'(motor_clr);
            if (k == 4) set_sw = 1'b0;
        end
        check_val("rev_set", 32'(ms_cnt), THROW_CYC);
        check_val("rev_clr", 32'(mc_cnt), THROW_CYC);
        sig = 4'b1010;
        cyc();
        cyc();
        check_val("rev_straight", 32'(sig_out), 32'hA);

        // Throw timeout
        do_reset();
        plant_mode = 0;
        set_sw     = 1'b1;
        sig        = 4'b1111;
        n          = 0;
        while (!fault && (n < 200)) begin
            cyc();
            n++;
        end
        check_val("to_edge", 32'(n), FB_TIMEOUT + 1);
        set_sw = 1'b0;
        repeat (5) cyc();
        check_val("to_sticky", 32'({sig_out, motor_set, motor_clr, fault}), 32'h1);

        // Settled-position mismatch, interrupted once by agreement
        do_reset();
        points_fb = 1'b1;
        repeat (40) cyc();
        check_val("mis_early", 32'(fault), 0);
        points_fb = 1'b0;
        cyc();
        points_fb = 1'b1;
        n = 0;
        while (!fault && (n < 200)) begin
            cyc();
            n++;
        end
        check_val("mis_edge", 32'(n), FB_TIMEOUT);

        // Reset mid-throw
        do_reset();
        set_sw = 1'b1;
        arrive = 4'b1111;
        repeat (4) cyc();
        check_val("mid_motor", 32'(motor_set), 1);
        check_val("mid_req", 32'(req), 32'hF);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst", 32'({req, sig_out, motor_set, motor_clr, fault}), 0);
        arrive = 4'b0000;
        set_sw = 1'b0;
        sig    = 4'b0011;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        check_val("mid_straight", 32'(sig_out), 32'h3);

        // Randomized traffic
        for (int ep = 0; ep < 8; ep++) begin
            plant_mode = 1 + (ep % 3);
            do_reset();
            if (ep == 7) plant_mode = 0;
            for (int k = 0; k < 300; k++) begin
                cyc();
                arrive = arrive ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
                depart = depart ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
                if ($urandom_range(7) == 0) sig = 4'($urandom);
                if ($urandom_range(39) == 0) set_sw = ~set_sw;
                if ((ep == 4) && (k == 150)) begin
                    #1 rst_n = 1'b0;
                    #1 rst_n = 1'b1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
